yu_multicycle_alu: RTL and testbench

//  Parametrised successor to the single-cycle ALU. Adds XOR, SLT/SLTU and shifts, plus

---
 rtl/yu_multicycle_alu_pkg.sv | 37 +++
 rtl/yu_seq_muldiv.sv | 78 +++++++
 rtl/yu_multicycle_alu.sv | 131 +++++++++++++
 tb/tb_yu_multicycle_alu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/yu_multicycle_alu_pkg.sv
// rtl/yu_multicycle_alu_pkg.sv - opcodes, FSM states and muldiv selectors for the Yu multicycle ALU
package yu_multicycle_alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_MUL   = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_MULHU = 4'd11;
  localparam logic [ALU_OP_W-1:0] ALU_DIVU  = 4'd12;
  localparam logic [ALU_OP_W-1:0] ALU_REMU  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  // bit 1 selects divide, bit 0 selects the upper half of the shared accumulator
  localparam logic [1:0] MD_MUL   = 2'd0;
  localparam logic [1:0] MD_MULHU = 2'd1;
  localparam logic [1:0] MD_DIVU  = 2'd2;
  localparam logic [1:0] MD_REMU  = 2'd3;

  function automatic logic is_muldiv(input logic [ALU_OP_W-1:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/yu_seq_muldiv.sv
// rtl/yu_seq_muldiv.sv - iterative shift-add multiplier and restoring divider
// One bit per cycle for XLEN cycles after start; done flags the final iteration.
module yu_seq_muldiv
  import yu_multicycle_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [1:0]        op_q;
  logic [CW-1:0]     cnt;
  logic              busy;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;

  // acc = {high, low}: product for mul, {remainder, quotient} for div
  always_comb begin
    acc_nxt   = acc;
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    if (op_q[1]) begin
      if (div_shift >= {1'b0, b_q})
        acc_nxt = {div_shift[XLEN-1:0] - b_q, acc[XLEN-2:0], 1'b1};
      else
        acc_nxt = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    end
  end

  assign done   = busy && (cnt == CW'(XLEN-1));
  assign result = op_q[0] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= MD_MUL;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (flush) begin
      acc  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= MD_MUL;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      acc  <= op[1] ? {{XLEN{1'b0}}, a} : {{XLEN{1'b0}}, b};
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/yu_multicycle_alu.sv
// rtl/yu_multicycle_alu.sv - multi-cycle ALU with valid/ready handshake
// Single-cycle ops resolve on the accept edge; mul/div run in yu_seq_muldiv.
module yu_multicycle_alu
  import yu_multicycle_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = ALU_OP_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [OP_W-1:0] in_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal
);

  localparam int SHW = $clog2(XLEN);

  alu_state_t      state;
  logic            accept;
  logic            op_is_md;
  logic [1:0]      md_op;
  logic            md_done;
  logic [XLEN-1:0] md_result;
  logic [XLEN-1:0] sc_result;
  logic            sc_illegal;
  logic [SHW-1:0]  shamt;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready && !flush;
  assign op_is_md = is_muldiv(in_op);
  assign shamt    = in_b[SHW-1:0];

  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
    case (in_op)
      ALU_ADD:  sc_result = in_a + in_b;
      ALU_SUB:  sc_result = in_a - in_b;
      ALU_AND:  sc_result = in_a & in_b;
      ALU_OR:   sc_result = in_a | in_b;
      ALU_XOR:  sc_result = in_a ^ in_b;
      ALU_SLT:  sc_result = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      ALU_SLTU: sc_result = {{(XLEN-1){1'b0}}, in_a < in_b};
      ALU_SLL:  sc_result = in_a << shamt;
      ALU_SRL:  sc_result = in_a >> shamt;
      ALU_SRA:  sc_result = $unsigned($signed(in_a) >>> shamt);
      ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU: sc_result = '0;
      default:  sc_illegal = 1'b1;
    endcase
  end

  always_comb begin
    md_op = MD_MUL;
    case (in_op)
      ALU_MULHU: md_op = MD_MULHU;
      ALU_DIVU:  md_op = MD_DIVU;
      ALU_REMU:  md_op = MD_REMU;
      default:   md_op = MD_MUL;
    endcase
  end

  yu_seq_muldiv #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (accept && op_is_md),
    .op     (md_op),
    .a      (in_a),
    .b      (in_b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      state       <= ST_IDLE;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op_is_md) begin
              state <= ST_BUSY;
            end else begin
              state       <= ST_DONE;
              out_valid   <= 1'b1;
              out_result  <= sc_result;
              out_illegal <= sc_illegal;
            end
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            state       <= ST_DONE;
            out_valid   <= 1'b1;
            out_result  <= md_result;
            out_illegal <= 1'b0;
          end
        end
        ST_DONE: begin
          // result held until the consumer takes it; re-accept only from IDLE
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_yu_multicycle_alu.sv
// tb/tb_yu_multicycle_alu.sv - scoreboard testbench for yu_multicycle_alu
module tb_yu_multicycle_alu;
  import yu_multicycle_alu_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_a = '0;
  logic [XLEN-1:0] in_b = '0;
  logic [3:0]      in_op = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_result;
  logic            out_illegal;

  int checks = 0;
  int errors = 0;
  logic [XLEN:0] sb_q[$];

  yu_multicycle_alu #(.XLEN(XLEN), .OP_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every transfer is compared against the oldest expected response
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result 0x%0h with empty scoreboard", out_result);
      end else begin
        logic [XLEN:0] exp;
        exp = sb_q.pop_front();
        check("out_result", 64'(out_result), 64'(exp[XLEN-1:0]));
        check("out_illegal", 64'(out_illegal), 64'(exp[XLEN]));
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp_r, input logic exp_i, input int exp_lat);
    int   lat;
    logic ready_bad;
    @(posedge clk); #1;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    sb_q.push_back({exp_i, exp_r});
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    ready_bad = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) ready_bad = 1'b1;
    end while (!out_valid && lat < 100);
    check("latency", 64'(lat), 64'(exp_lat));
    if (exp_lat > 1) check("in_ready_busy", 64'(ready_bad), 64'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    rst = 1'b0;

    // reset in the middle of a divide
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = ALU_DIVU; in_a = 32'd100; in_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_result", 64'(out_result), 64'd0);
    check("midrst_out_illegal", 64'(out_illegal), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("postrst_in_ready", 64'(in_ready), 64'd1);

    // single-cycle ops
    run_op(ALU_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1);
    run_op(ALU_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1);
    run_op(ALU_AND,  32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 1'b0, 1);
    run_op(ALU_OR,   32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFFF0_FFF0, 1'b0, 1);
    run_op(ALU_XOR,  32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFF00_0FF0, 1'b0, 1);
    run_op(ALU_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1);
    run_op(ALU_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1);
    run_op(ALU_SLL,  32'h1,         32'h23,        32'h8,         1'b0, 1);
    run_op(ALU_SRL,  32'h8000_0000, 32'h4,         32'h0800_0000, 1'b0, 1);
    run_op(ALU_SRA,  32'h8000_0000, 32'h4,         32'hF800_0000, 1'b0, 1);

    // iterative ops
    run_op(ALU_MUL,   32'h1_0000,     32'h1_0000,     32'h0,         1'b0, XLEN+1);
    run_op(ALU_MULHU, 32'h1_0000,     32'h1_0000,     32'h1,         1'b0, XLEN+1);
    run_op(ALU_MUL,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h1,         1'b0, XLEN+1);
    run_op(ALU_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 1'b0, XLEN+1);
    run_op(ALU_DIVU,  32'd100,        32'd7,          32'd14,        1'b0, XLEN+1);
    run_op(ALU_REMU,  32'd100,        32'd7,          32'd2,         1'b0, XLEN+1);
    run_op(ALU_DIVU,  32'd5,          32'd0,          32'hFFFF_FFFF, 1'b0, XLEN+1);
    run_op(ALU_REMU,  32'd5,          32'd0,          32'd5,         1'b0, XLEN+1);
    run_op(ALU_DIVU,  32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF, 1'b0, XLEN+1);
    run_op(ALU_REMU,  32'hFFFF_FFFF,  32'h10,         32'hF,         1'b0, XLEN+1);

    // backpressure: result held while a new op waits on in_valid
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = ALU_XOR; in_a = 32'h1234_5678; in_b = 32'hFFFF_FFFF;
    sb_q.push_back({1'b0, 32'hEDCB_A987});
    @(posedge clk); #1;
    in_op = ALU_ADD; in_a = 32'd1; in_b = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_result", 64'(out_result), 64'hEDCB_A987);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("xfer_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("postxfer_in_ready", 64'(in_ready), 64'd1);
    check("postxfer_out_valid", 64'(out_valid), 64'd0);
    sb_q.push_back({1'b0, 32'd3});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_out_valid", 64'(out_valid), 64'd1);

    // flush during a multiply with in_valid also high
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = ALU_MUL; in_a = 32'd3; in_b = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1; in_op = ALU_ADD; in_a = 32'd5; in_b = 32'd6;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < XLEN + 4; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      check("flush_no_output", 64'(seen), 64'd0);
    end

    // undefined opcodes
    run_op(4'd15, 32'h1234_5678, 32'h1, 32'h0, 1'b1, 1);
    run_op(4'd14, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1);
    run_op(ALU_ADD, 32'd7, 32'd8, 32'd15, 1'b0, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
